// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: board switch / confirm button input peripheral.
// The switches and button pass through two-flop synchronizers. The button is debounced by a
// four-state FSM. Each accepted press latches the switch word into a holding register and
// sets data_valid. The CPU reads the data word or the status word combinationally. A data
// read consumes the held word.
// Optional feature macro: SWITCH_OVERRUN_EN. When it is defined, the block keeps a sticky
// overrun flag. It is readable as status bit 1 and is cleared by a status read.
module switch_input_ctrl #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] switches,
  input  logic                  confirm_button,
  input  logic                  ior,
  input  logic                  switchctrl,
  input  logic [1:0]            ioaddr,
  output logic [DATA_WIDTH-1:0] ioread_data,
  output logic                  data_valid,
  output logic                  btn_level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressChk,
    StPressed,
    StRelChk
  } state_e;

  logic [DATA_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic                  btn_meta_q, btn_s_q;
  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  btn_level_q;
  logic [DATA_WIDTH-1:0] data_reg_q;
  logic                  data_valid_q;
  logic                  overrun_q;
  logic                  capture;
  logic                  rd_data;
  logic                  rd_status;
  logic [DATA_WIDTH-1:0] status_word;

  // Two-flop synchronizers for the asynchronous switch bus and button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= confirm_button;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Debounce FSM. The counter restarts on every state change. btn_level is registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StReleased;
      cnt_q       <= '0;
      btn_level_q <= 1'b0;
    end else begin
      unique case (state_q)
        StReleased: begin
          if (btn_s_q) begin
            state_q <= StPressChk;
            cnt_q   <= '0;
          end
        end
        StPressChk: begin
          if (!btn_s_q) begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= StPressed;
            cnt_q       <= '0;
            btn_level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!btn_s_q) begin
            state_q <= StRelChk;
            cnt_q   <= '0;
          end
        end
        StRelChk: begin
          if (btn_s_q) begin
            // Bounce during release: return to PRESSED without a new capture.
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= StReleased;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  // Capture fires on the edge where PRESS_CHK completes, so there is one capture per press.
  assign capture   = (state_q == StPressChk) && btn_s_q && (cnt_q == CntLast);
  assign rd_data   = ior && switchctrl && (ioaddr == 2'b00);
  assign rd_status = ior && switchctrl && (ioaddr == 2'b01);

  // Holding register. A capture takes priority over the clear caused by a data read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (capture) begin
      data_reg_q   <= sw_sync_q;
      data_valid_q <= 1'b1;
    end else if (rd_data) begin
      data_valid_q <= 1'b0;
    end
  end

`ifdef SWITCH_OVERRUN_EN
  // Sticky overrun flag. Setting it takes priority over the clear from a status read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (capture && data_valid_q) begin
      overrun_q <= 1'b1;
    end else if (rd_status) begin
      overrun_q <= 1'b0;
    end
  end
`else
  assign overrun_q = 1'b0;
`endif

  // Status word and the combinational read mux. Unselected or unmapped reads return 0.
  always_comb begin
    status_word    = '0;
    status_word[0] = data_valid_q;
    status_word[1] = overrun_q;
    ioread_data    = '0;
    if (rd_data) begin
      ioread_data = data_reg_q;
    end else if (rd_status) begin
      ioread_data = status_word;
    end
  end

  assign data_valid = data_valid_q;
  assign btn_level  = btn_level_q;

endmodule
